// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing with divider FSM and stall counter
module hazard_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        div_start,
  input  logic        exmem_memop,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] stall_cnt
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES - 1);
  state_t      r_state, w_state_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_stall_cnt;
  logic        w_mem_wait, w_load_use, w_div_stall;
  assign w_mem_wait  = exmem_memop & ~dmem_ready;
  assign w_load_use  = idex_memread & (idex_rt != 5'd0) &
                       ((id_uses_rs & (id_rs == idex_rt)) | (id_uses_rt & (id_rt == idex_rt)));
  assign w_div_stall = ((r_state == IDLE) & div_start) | (r_state == BUSY);
  assign stall_cnt   = r_stall_cnt;
  // Prioritised hazard resolution; reset forces a free-running pipeline
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    div_busy     = ~rst & (r_state == BUSY);
    div_done     = ~rst & (r_state == DONE);
    if (!rst) begin
      if (w_mem_wait) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end else if (w_div_stall) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_bubble = 1'b1;
      end else if (w_load_use) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end else begin
        ifid_flush = branch_taken;
      end
    end
  end
  // Divider occupancy FSM; BUSY counts down regardless of memory wait
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (div_start) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = CNT_INIT;
      end
      BUSY: if (r_cnt == 6'd0) w_state_nxt = DONE;
            else w_cnt_nxt = r_cnt - 6'd1;
      DONE: w_state_nxt = w_mem_wait ? DONE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // State registers and saturating count of PC-stalled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 6'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!pc_en && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard priority, divider FSM and stall counter
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, idex_rt = 5'd0;
  logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, idex_memread = 1'b0;
  logic        div_start = 1'b0, exmem_memop = 1'b0, dmem_ready = 1'b1, branch_taken = 1'b0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_bubble, exmem_bubble, div_busy, div_done;
  logic [31:0] stall_cnt;
  logic [9:0]  outs;
  int          errors = 0;
  int          checks = 0;
  localparam logic [9:0] RUN   = 10'b11111_000_00;
  localparam logic [9:0] FLUSH = 10'b11111_100_00;
  localparam logic [9:0] LU    = 10'b00111_010_00;
  localparam logic [9:0] FRZ   = 10'b00000_000_00;
  localparam logic [9:0] DIV0  = 10'b00011_001_00;
  localparam logic [9:0] DIVB  = 10'b00011_001_10;
  localparam logic [9:0] DONE  = 10'b11111_000_01;
  localparam logic [9:0] FRZD  = 10'b00000_000_01;

  hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .div_start(div_start),
    .exmem_memop(exmem_memop), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .div_busy(div_busy), .div_done(div_done),
    .stall_cnt(stall_cnt)
  );

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_bubble, exmem_bubble, div_busy, div_done};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; idex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; idex_memread = 1'b0;
    div_start = 1'b0; exmem_memop = 1'b0; dmem_ready = 1'b1; branch_taken = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    cyc(); #1;
    chk("rst_outs", {22'd0, outs}, {22'd0, RUN});
    rst = 1'b0; #1;
    chk("post_rst_outs", {22'd0, outs}, {22'd0, RUN});
    chk("post_rst_cnt", stall_cnt, 32'd0);

    cyc(); idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1; #1;
    chk("lu_rs", {22'd0, outs}, {22'd0, LU});
    cyc(); idle_inputs(); #1;
    chk("lu_release", {22'd0, outs}, {22'd0, RUN});
    chk("lu_cnt", stall_cnt, 32'd1);
    cyc(); idex_memread = 1'b1; id_uses_rs = 1'b1; #1;
    chk("lu_r0", {22'd0, outs}, {22'd0, RUN});
    cyc(); idle_inputs(); #1;
    chk("lu_r0_cnt", stall_cnt, 32'd1);

    cyc(); idex_memread = 1'b1; idex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; branch_taken = 1'b1; #1;
    chk("lu_br", {22'd0, outs}, {22'd0, LU});
    cyc(); idex_memread = 1'b0; #1;
    chk("br_flush", {22'd0, outs}, {22'd0, FLUSH});
    chk("lu_br_cnt", stall_cnt, 32'd2);

    cyc(); idle_inputs(); exmem_memop = 1'b1; dmem_ready = 1'b0; #1;
    chk("mw1", {22'd0, outs}, {22'd0, FRZ});
    cyc(); #1;
    chk("mw2", {22'd0, outs}, {22'd0, FRZ});
    cyc(); idex_memread = 1'b1; idex_rt = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1; branch_taken = 1'b1; #1;
    chk("mw3_lu", {22'd0, outs}, {22'd0, FRZ});
    cyc(); dmem_ready = 1'b1; #1;
    chk("mw_then_lu", {22'd0, outs}, {22'd0, LU});
    cyc(); idle_inputs(); #1;
    chk("mw_release", {22'd0, outs}, {22'd0, RUN});
    chk("mw_cnt", stall_cnt, 32'd6);

    cyc(); div_start = 1'b1; #1;
    chk("div_start", {22'd0, outs}, {22'd0, DIV0});
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk($sformatf("div_busy%0d", i), {22'd0, outs}, {22'd0, DIVB});
    end
    cyc(); #1;
    chk("div_done", {22'd0, outs}, {22'd0, DONE});
    chk("div_cnt", stall_cnt, 32'd11);
    cyc(); #1;
    chk("div2_start", {22'd0, outs}, {22'd0, DIV0});
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk($sformatf("div2_busy%0d", i), {22'd0, outs}, {22'd0, DIVB});
    end
    cyc(); exmem_memop = 1'b1; dmem_ready = 1'b0; #1;
    chk("done_mw1", {22'd0, outs}, {22'd0, FRZD});
    cyc(); #1;
    chk("done_mw2", {22'd0, outs}, {22'd0, FRZD});
    cyc(); dmem_ready = 1'b1; div_start = 1'b0; #1;
    chk("done_release", {22'd0, outs}, {22'd0, DONE});
    cyc(); idle_inputs(); #1;
    chk("div2_idle", {22'd0, outs}, {22'd0, RUN});
    chk("div2_cnt", stall_cnt, 32'd18);

    cyc(); div_start = 1'b1; #1;
    cyc(); #1;
    chk("rb_busy_a", {22'd0, outs}, {22'd0, DIVB});
    cyc(); rst = 1'b1; #1;
    chk("rb_rst_outs", {22'd0, outs}, {22'd0, RUN});
    cyc(); rst = 1'b0; div_start = 1'b0; #1;
    chk("rb_after", {22'd0, outs}, {22'd0, RUN});
    chk("rb_cnt", stall_cnt, 32'd0);
    cyc(); #1;
    chk("rb_no_done", {22'd0, outs}, {22'd0, RUN});

    cyc(); force dut.r_stall_cnt = 32'hFFFF_FFFE; #1; release dut.r_stall_cnt;
    exmem_memop = 1'b1; dmem_ready = 1'b0; #1;
    chk("sat_pre", stall_cnt, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk($sformatf("sat%0d", i), stall_cnt, 32'hFFFF_FFFF);
    end
    cyc(); idle_inputs(); #1;
    chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
